// File: rtl/corescore_reset_sequencer.sv
// Reset sequencer: qualifies MMCM lock for HOLD_CYCLES, then releases CHANNELS
// resets in ascending order STAGGER cycles apart, and counts losses of established lock.
module corescore_reset_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGGER     = 16,
    parameter int CNT_W       = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_locked,
    input  logic                i_force,
    output logic [CHANNELS-1:0] o_rst,
    output logic                o_ready,
    output logic [CNT_W-1:0]    o_lock_losses,
    output logic [1:0]          o_state
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_RELOAD = STG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic                sync_meta, locked_s;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx, hold_inc;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [STG_W-1:0]    stg_cnt, stg_nx;
    logic [CHANNELS-1:0] rst_nx;
    logic                ready_nx;
    logic [CNT_W-1:0]    losses_nx;
    logic                lost;

    // Two-flop synchroniser; only locked_s is seen by the sequencing logic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= i_locked;
            locked_s  <= sync_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= WAIT_LOCK;
            hold_cnt      <= '0;
            idx           <= '0;
            stg_cnt       <= '0;
            o_rst         <= '1;
            o_ready       <= 1'b0;
            o_lock_losses <= '0;
        end else begin
            state         <= state_nx;
            hold_cnt      <= hold_nx;
            idx           <= idx_nx;
            stg_cnt       <= stg_nx;
            o_rst         <= rst_nx;
            o_ready       <= ready_nx;
            o_lock_losses <= losses_nx;
        end
    end

    assign hold_inc = hold_cnt + 1'b1;

    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        idx_nx    = idx;
        stg_nx    = stg_cnt;
        rst_nx    = o_rst;
        ready_nx  = 1'b0;
        losses_nx = o_lock_losses;

        // Only a lock that had already been qualified counts as a loss.
        lost = !locked_s && (state == RELEASE || state == RUN);
        if (lost && (o_lock_losses != '1)) begin
            losses_nx = o_lock_losses + 1'b1;
        end

        if (i_force || lost) begin
            state_nx = WAIT_LOCK;
            rst_nx   = '1;
            hold_nx  = '0;
            idx_nx   = '0;
            stg_nx   = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_nx = '1;
                    if (locked_s) begin
                        hold_nx  = '0;
                        idx_nx   = '0;
                        stg_nx   = '0;
                        state_nx = (HOLD_CYCLES == 1) ? RELEASE : HOLD;
                    end
                end
                HOLD: begin
                    rst_nx = '1;
                    if (!locked_s) begin
                        state_nx = WAIT_LOCK;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_inc;
                        if (hold_inc == HOLD_LAST) begin
                            state_nx = RELEASE;
                            idx_nx   = '0;
                            stg_nx   = '0;
                        end
                    end
                end
                RELEASE: begin
                    // Channel idx is released when the stagger countdown hits zero.
                    if (stg_cnt == '0) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (IDX_W'(k) == idx) begin
                                rst_nx[k] = 1'b0;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state_nx = RUN;
                        end else begin
                            idx_nx = idx + 1'b1;
                            stg_nx = STG_RELOAD;
                        end
                    end else begin
                        stg_nx = stg_cnt - 1'b1;
                    end
                end
                RUN: begin
                    rst_nx   = '0;
                    ready_nx = 1'b1;
                end
                default: begin
                    state_nx = WAIT_LOCK;
                    rst_nx   = '1;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule
